// File: rtl/qam_pkg.sv
// Shared types and constants for the QAM-16 frame synchroniser.
package qam_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2
    } sync_state_t;

    // Nibbles in one sync word; also the hunt-count saturation point.
    localparam int SYNC_NIBBLES = 4;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } byte_entry_t;

    // Saturating increment of the hunt counter (never exceeds SYNC_NIBBLES).
    function automatic logic [2:0] hunt_inc(input logic [2:0] cnt);
        return (cnt >= 3'(SYNC_NIBBLES)) ? cnt : cnt + 3'd1;
    endfunction

endpackage

// File: rtl/qam_frame_sync_if.sv
// Symbol input stream and byte output stream of the frame synchroniser.
// The slave modport is the framer's view; master is the surrounding system.
interface qam_frame_sync_if;

    logic       sym_valid;
    logic [3:0] sym_in;
    logic       m_tvalid;
    logic       m_tready;
    logic [7:0] m_tdata;
    logic       m_tlast;

    modport master (
        output sym_valid, sym_in, m_tready,
        input  m_tvalid, m_tdata, m_tlast
    );

    modport slave (
        input  sym_valid, sym_in, m_tready,
        output m_tvalid, m_tdata, m_tlast
    );

endinterface

// File: rtl/qam_sync_fifo.sv
// Show-ahead byte FIFO. Pointers carry an extra wrap bit; an explicit
// occupancy count drives full/empty. Writes while full are refused.
module qam_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             wr_ok, rd_ok;

    // Full is judged on the registered count, so a simultaneous pop never
    // makes room for a write in the same cycle.
    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign wr_ok   = wr_en_i && !full_o;
    assign rd_ok   = rd_en_i && !empty_o;

    // Head entry is presented combinationally; zero while empty so the
    // byte port reads 0 out of reset.
    assign rd_data_o = empty_o ? '0 : mem[rd_ptr_q[AW-1:0]];

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ok ? wr_ptr_q + CNT_ONE : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + CNT_ONE : rd_ptr_q;
        count_d  = count_q;
        if (wr_ok && !rd_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (!wr_ok && rd_ok) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Pointer/count registers; reset empties the FIFO immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, written only on accepted pushes.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/qam_frame_sync.sv
// Frame synchroniser after the QAM-16 demodulator: hunts for the sync word,
// reads a one-byte length, packs payload nibbles into bytes and queues them
// on a valid/ready byte stream with tlast on the final byte of each frame.
module qam_frame_sync
    import qam_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD  = 16'hEB90,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic            axi_clk,
    input  logic            axi_rstn,
    qam_frame_sync_if.slave bus,
    output logic            sync_lock,
    output logic            frame_done,
    output logic            ovf
);

    localparam logic [1:0] ST_HUNT    = HUNT;
    localparam logic [1:0] ST_LEN     = LEN;
    localparam logic [1:0] ST_PAYLOAD = PAYLOAD;

    logic [1:0]  state_q, state_d;
    logic [11:0] sr_q, sr_d;           // last three nibbles seen while hunting
    logic [2:0]  hunt_q, hunt_d;       // nibbles seen since entering HUNT, saturating
    logic [7:0]  len_q, len_d;
    logic [3:0]  hi_q, hi_d;           // first (high) nibble of the pair in flight
    logic        half_q, half_d;       // high nibble already captured
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic        push_q, push_d;
    byte_entry_t push_entry_q, push_entry_d;
    logic        ovf_q, ovf_d;

    logic [15:0] window;
    logic [7:0]  nib_pair;
    logic        last_byte;
    logic        fifo_full, fifo_empty, pop;
    logic [8:0]  head_raw;
    byte_entry_t head;

    assign window    = {sr_q, bus.sym_in};
    assign nib_pair  = {hi_q, bus.sym_in};
    assign last_byte = (byte_cnt_q == len_q - 8'd1);

    // Framer next-state: only strobed symbols move anything forward.
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        hunt_d       = hunt_q;
        len_d        = len_q;
        hi_d         = hi_q;
        half_d       = half_q;
        byte_cnt_d   = byte_cnt_q;
        push_d       = 1'b0;
        push_entry_d = push_entry_q;
        if (bus.sym_valid) begin
            case (state_q)
                ST_HUNT: begin
                    sr_d   = window[11:0];
                    hunt_d = hunt_inc(hunt_q);
                    // Hunt count guarantees all four matching nibbles arrived
                    // after the search (re)started.
                    if (window == SYNC_WORD && hunt_inc(hunt_q) >= 3'(SYNC_NIBBLES)) begin
                        state_d = ST_LEN;
                        half_d  = 1'b0;
                    end
                end
                ST_LEN: begin
                    if (!half_q) begin
                        hi_d   = bus.sym_in;
                        half_d = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        len_d  = nib_pair;
                        if (nib_pair == 8'd0) begin
                            state_d = ST_HUNT;
                            sr_d    = '0;
                            hunt_d  = '0;
                        end else begin
                            state_d    = ST_PAYLOAD;
                            byte_cnt_d = '0;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (!half_q) begin
                        hi_d   = bus.sym_in;
                        half_d = 1'b1;
                    end else begin
                        half_d            = 1'b0;
                        push_d            = 1'b1;
                        push_entry_d.data = nib_pair;
                        push_entry_d.last = last_byte;
                        // Counts every byte, dropped or not, to keep framing aligned.
                        byte_cnt_d        = byte_cnt_q + 8'd1;
                        if (last_byte) begin
                            state_d = ST_HUNT;
                            sr_d    = '0;
                            hunt_d  = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    sr_d    = '0;
                    hunt_d  = '0;
                end
            endcase
        end
    end

    // A push attempted against a full FIFO latches the overflow flag for good.
    assign ovf_d = ovf_q | (push_q & fifo_full);

    // Framer, packer and overflow registers.
    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state_q      <= ST_HUNT;
            sr_q         <= '0;
            hunt_q       <= '0;
            len_q        <= '0;
            hi_q         <= '0;
            half_q       <= 1'b0;
            byte_cnt_q   <= '0;
            push_q       <= 1'b0;
            push_entry_q <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            hunt_q       <= hunt_d;
            len_q        <= len_d;
            hi_q         <= hi_d;
            half_q       <= half_d;
            byte_cnt_q   <= byte_cnt_d;
            push_q       <= push_d;
            push_entry_q <= push_entry_d;
            ovf_q        <= ovf_d;
        end
    end

    assign pop = bus.m_tvalid && bus.m_tready;

    qam_sync_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (axi_clk),
        .rst_n     (axi_rstn),
        .wr_en_i   (push_q),
        .wr_data_i (push_entry_q),
        .rd_en_i   (pop),
        .rd_data_o (head_raw),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign head         = byte_entry_t'(head_raw);
    assign bus.m_tvalid = !fifo_empty;
    assign bus.m_tdata  = head.data;
    assign bus.m_tlast  = head.last;

    assign sync_lock  = (state_q == ST_LEN) || (state_q == ST_PAYLOAD);
    // Pulses even when the final byte is dropped on a full FIFO.
    assign frame_done = push_q && push_entry_q.last;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_qam_frame_sync.sv
// Bench for qam_frame_sync: directed and randomized symbol streams, with the
// expected byte stream produced by a search-and-parse model over the list of
// accepted nibbles.
module tb_qam_frame_sync;

    localparam logic [15:0] SYNC = 16'hEB90;

    logic clk;
    logic rstn;
    logic sync_lock, frame_done, ovf;

    qam_frame_sync_if bus();

    qam_frame_sync #(
        .SYNC_WORD  (SYNC),
        .FIFO_DEPTH (16)
    ) dut (
        .axi_clk    (clk),
        .axi_rstn   (rstn),
        .bus        (bus),
        .sync_lock  (sync_lock),
        .frame_done (frame_done),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] nib_q[$];      // every nibble accepted by the DUT since reset
    logic [8:0] got_q[$];      // {last, data} popped from the DUT since reset
    logic [8:0] exp_q[$];
    int         exp_frames;
    int         fd_cnt = 0;
    int         checked_idx = 0;
    bit         rand_rdy = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Collect popped bytes and frame_done pulses, away from the active edge.
    always @(negedge clk) begin
        if (rstn && bus.m_tvalid && bus.m_tready) begin
            got_q.push_back({bus.m_tlast, bus.m_tdata});
            $display("%0t pop data=%02h last=%0d", $time, bus.m_tdata, bus.m_tlast);
        end
        if (rstn && frame_done) fd_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) bus.m_tready = ($urandom_range(3) != 0);
    endtask

    task automatic drive_nib(input logic [3:0] n, input int gap_pct);
        while (int'($urandom_range(99)) < gap_pct) begin
            bus.sym_valid = 1'b0;
            bus.sym_in    = 4'($urandom);
            tick();
        end
        bus.sym_valid = 1'b1;
        bus.sym_in    = n;
        nib_q.push_back(n);
        tick();
        bus.sym_valid = 1'b0;
    endtask

    // Drive the low cnt nibbles of w, most significant first.
    task automatic drive_word(input logic [63:0] w, input int cnt, input int gap_pct);
        for (int i = cnt - 1; i >= 0; i--) drive_nib(w[4*i +: 4], gap_pct);
    endtask

    // Scan the accepted nibbles: find a sync word starting at or after the
    // search point, read a length byte, take 2*len payload nibbles, repeat.
    function automatic void build_model();
        int n = nib_q.size();
        int p = 0;
        int found;
        int len;
        exp_q.delete();
        exp_frames = 0;
        while (p + 4 <= n) begin
            found = -1;
            for (int k = p; k + 4 <= n; k++) begin
                if ({nib_q[k], nib_q[k+1], nib_q[k+2], nib_q[k+3]} == SYNC) begin
                    found = k;
                    break;
                end
            end
            if (found < 0) break;
            p = found + 4;
            if (p + 2 > n) break;
            len = int'({nib_q[p], nib_q[p+1]});
            p += 2;
            if (len == 0) continue;
            for (int b = 0; b < len && p + 2*b + 2 <= n; b++)
                exp_q.push_back({(b == len - 1), nib_q[p+2*b], nib_q[p+2*b+1]});
            if (p + 2*len > n) break;
            exp_frames++;
            p += 2*len;
        end
    endfunction

    task automatic compare_stream(input string tag);
        int waited = 0;
        build_model();
        while (got_q.size() < exp_q.size() && waited < 600) begin
            tick();
            waited++;
        end
        repeat (8) tick();
        check_val({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = checked_idx; i < exp_q.size() && i < got_q.size(); i++)
            check_val({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
        checked_idx = exp_q.size();
        check_val({tag, "_frames"}, 32'(fd_cnt), 32'(exp_frames));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, got_base, fd_base, len;
        rstn          = 1'b0;
        bus.sym_valid = 1'b0;
        bus.sym_in    = 4'h0;
        bus.m_tready  = 1'b0;
        tick();
        tick();
        check_val("rst_tvalid", 32'(bus.m_tvalid), 32'd0);
        check_val("rst_tdata",  32'(bus.m_tdata),  32'd0);
        check_val("rst_tlast",  32'(bus.m_tlast),  32'd0);
        check_val("rst_lock",   32'(sync_lock),    32'd0);
        check_val("rst_fdone",  32'(frame_done),   32'd0);
        check_val("rst_ovf",    32'(ovf),          32'd0);
        rstn = 1'b1;
        tick();

        // 1: basic two-byte frame, plus lock and latency
        bus.m_tready = 1'b1;
        drive_word(64'hEB9, 3, 0);
        check_val("t1_lock_pre", 32'(sync_lock), 32'd0);
        drive_word(64'h0, 1, 0);
        check_val("t1_lock_on", 32'(sync_lock), 32'd1);
        drive_word(64'h0212, 4, 0);
        check_val("t1_lat_push", 32'(bus.m_tvalid), 32'd0);
        tick();
        check_val("t1_lat_valid", 32'(bus.m_tvalid), 32'd1);
        check_val("t1_lat_data", 32'(bus.m_tdata), 32'h12);
        drive_word(64'h34, 2, 0);
        check_val("t1_fdone", 32'(frame_done), 32'd1);
        check_val("t1_lock_off", 32'(sync_lock), 32'd0);
        compare_stream("t1");

        // 2: partial sync inside noise, then a real one
        drive_word(64'hAEB9EB9, 7, 0);
        check_val("t2_lock_partial", 32'(sync_lock), 32'd0);
        drive_word(64'h0, 1, 0);
        check_val("t2_lock_full", 32'(sync_lock), 32'd1);
        drive_word(64'h0356789A, 8, 0);
        compare_stream("t2");

        // 3: zero-length frame, then a one-byte frame
        drive_word(64'hEB9000, 6, 0);
        check_val("t3_lock_len0", 32'(sync_lock), 32'd0);
        drive_word(64'hEB9001CD, 8, 0);
        compare_stream("t3");

        // 5: random frames with 50% symbol gaps and random downstream ready
        rand_rdy = 1;
        for (int f = 0; f < 6; f++) begin
            for (int j = int'($urandom_range(3)); j > 0; j--) drive_nib(4'($urandom), 50);
            drive_word(64'(SYNC), 4, 50);
            len = int'($urandom_range(10, 1));
            drive_word(64'(len), 2, 50);
            for (int b = 0; b < 2*len; b++) drive_nib(4'($urandom), 50);
        end
        compare_stream("t5");
        rand_rdy = 0;
        bus.m_tready = 1'b1;
        check_val("t5_ovf", 32'(ovf), 32'd0);

        // 4: 20-byte frame into a stalled 16-deep FIFO
        bus.m_tready = 1'b0;
        base     = checked_idx;
        got_base = got_q.size();
        fd_base  = fd_cnt;
        drive_word(64'hEB9014, 6, 0);
        for (int b = 0; b < 40; b++) drive_nib(4'($urandom), 0);
        repeat (3) tick();
        build_model();
        check_val("t4_ovf", 32'(ovf), 32'd1);
        check_val("t4_fdone", 32'(fd_cnt - fd_base), 32'd1);
        check_val("t4_held", 32'(bus.m_tvalid), 32'd1);
        bus.m_tready = 1'b1;
        repeat (24) tick();
        check_val("t4_count", 32'(got_q.size() - got_base), 32'd16);
        for (int i = 0; i < 16 && got_base + i < got_q.size(); i++)
            check_val("t4_byte", 32'(got_q[got_base+i]), 32'(exp_q[base+i]));

        // 6: reset after three payload bytes are queued
        bus.m_tready = 1'b0;
        drive_word(64'hEB9008, 6, 0);
        drive_word(64'h123456, 6, 0);
        tick();
        check_val("t6_pre_valid", 32'(bus.m_tvalid), 32'd1);
        #3;
        rstn = 1'b0;
        #1;
        check_val("t6_rst_valid", 32'(bus.m_tvalid), 32'd0);
        check_val("t6_rst_tdata", 32'(bus.m_tdata), 32'd0);
        check_val("t6_rst_ovf", 32'(ovf), 32'd0);
        check_val("t6_rst_lock", 32'(sync_lock), 32'd0);
        nib_q.delete();
        got_q.delete();
        checked_idx = 0;
        fd_cnt = 0;
        tick();
        rstn = 1'b1;
        bus.m_tready = 1'b1;
        tick();
        drive_word(64'hEB9003A1B2C3, 12, 0);
        compare_stream("t6");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
